// File: rtl/imem_loader.sv
// imem_loader: boot-time filler for the fetch-stage instruction memory.
// A byte stream (valid/ready) carries a 4-byte big-endian word count N
// followed by N big-endian 32-bit words. Each word is written to
// consecutive word addresses from 0. The CPU is held in stall until the
// load completes successfully.
//
// Handshake: a byte transfers on a posedge where in_valid && in_ready are
// both high. in_ready depends only on the state (HDR or DATA), never on
// in_valid. The source may drop in_valid at any time, and in_data is
// ignored unless a transfer takes place.
module imem_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              hold_cpu,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam logic [31:0]     DEPTH_W = 32'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_bcnt;      // bytes already taken of the current word
    logic [23:0]       r_asm;       // the three most recent bytes
    logic [ADDR_W:0]   r_words;     // word index == words written this load
    logic [ADDR_W:0]   r_n;         // latched word count from the header
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_word_done;
    logic              w_last_word;
    logic              w_start_ok;
    logic [31:0]       w_word;
    logic [ADDR_W:0]   w_words_inc;

    // The accepted byte is the low byte, so w_word is the completed word on the 4th accept.
    assign w_word      = {r_asm, in_data};
    assign w_accept    = in_valid && w_in_ready;
    assign w_word_done = w_accept && (r_bcnt == 2'd3);
    assign w_words_inc = r_words + ONE_W;
    assign w_last_word = (w_words_inc == r_n);
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                   (r_state == S_ERROR));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        hold_cpu    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                w_in_ready = 1'b1;
                busy       = 1'b1;
                if (w_word_done) begin
                    if (w_word == 32'd0)        w_state_nxt = S_DONE;
                    else if (w_word > DEPTH_W)  w_state_nxt = S_ERROR;
                    else                        w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                w_in_ready = 1'b1;
                busy       = 1'b1;
                // Leaving on the Nth word means in_ready is already low in the strobe cycle.
                if (w_word_done && w_last_word) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                hold_cpu = 1'b0;
                if (start) w_state_nxt = S_HDR;
            end
            S_ERROR: begin
                error = 1'b1;
                if (start) w_state_nxt = S_HDR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Byte assembly, header latch and one-cycle write strobe generation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcnt  <= 2'd0;
            r_asm   <= 24'd0;
            r_words <= '0;
            r_n     <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_bcnt  <= 2'd0;
                r_words <= '0;
            end else if (w_accept) begin
                r_bcnt <= r_bcnt + 2'd1;
                r_asm  <= w_word[23:0];
                if (w_word_done && (r_state == S_HDR)) begin
                    // Only meaningful when the count is legal; unused otherwise.
                    r_n <= w_word[ADDR_W:0];
                end
                if (w_word_done && (r_state == S_DATA)) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_words[ADDR_W-1:0];
                    r_wdata <= w_word;
                    r_words <= w_words_inc;
                end
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign mem_we       = r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed sequence of loads with randomized payloads and
// randomized in_valid throttling, checked against a stream-level model of
// the expected memory writes.
module tb_imem_loader;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    // Clock and reset
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              hold_cpu;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .hold_cpu     (hold_cpu),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int                checks_total  = 0;
    int                checks_passed = 0;
    logic [35:0]       exp_q[$];
    logic [35:0]       obs_q[$];
    int                obs_cyc_q[$];
    int                done_cyc_q[$];
    logic [31:0]       gen_words[$];
    logic [7:0]        byte_q[$];

    // Write monitor: record every strobe with the cycle it was seen in.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            obs_q.push_back({mem_addr, mem_wdata});
            obs_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: header then big-endian words; writes only for 1..DEPTH.
    task automatic build_bytes(input logic [31:0] n_hdr);
        byte_q.delete();
        for (int b = 3; b >= 0; b--) byte_q.push_back(n_hdr[b*8 +: 8]);
        foreach (gen_words[k]) begin
            for (int b = 3; b >= 0; b--) byte_q.push_back(gen_words[k][b*8 +: 8]);
        end
    endtask

    task automatic model_load(input logic [31:0] n, input int words_sent);
        exp_q.delete();
        if (n >= 1 && n <= DEPTH) begin
            for (int k = 0; k < n && k < words_sent; k++)
                exp_q.push_back({ADDR_W'(k), gen_words[k]});
        end
    endtask

    task automatic rand_words(input int cnt);
        gen_words.delete();
        for (int k = 0; k < cnt; k++) gen_words.push_back($urandom);
    endtask

    // Driver tasks
    task automatic start_load();
        @(negedge clk);
        obs_q.delete();
        obs_cyc_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_done_clr", done, 0);
        chk("start_err_clr", error, 0);
        chk("start_hold", hold_cpu, 1);
        chk("start_busy", busy, 1);
        chk("start_words_clr", words_loaded, 0);
    endtask

    task automatic drive_bytes(input int n_bytes, input int start_at, input bit throttle);
        int i;
        int waitc;
        bit acc;
        bit pulsed;
        i = 0;
        waitc = 0;
        pulsed = 1'b0;
        done_cyc_q.delete();
        while (i < n_bytes) begin
            @(negedge clk);
            in_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? byte_q[i] : 8'($urandom);
            start    = (i == start_at) && !pulsed;
            if (start) pulsed = 1'b1;
            acc = in_valid && (in_ready === 1'b1);
            if (acc) begin
                if (i >= 4 && (i % 4) == 3) done_cyc_q.push_back(cyc);
                i++;
                waitc = 0;
            end else begin
                waitc++;
                if (waitc > 200) begin
                    checks_total++;
                    $error("FAIL byte_timeout: observed byte %0d not accepted expected accept within 200 cycles", i);
                    break;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        repeat (2) @(negedge clk);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            chk($sformatf("%s_wr%0d", tag, k), obs_q[k], exp_q[k]);
            if (k < done_cyc_q.size())
                chk($sformatf("%s_lat%0d", tag, k), obs_cyc_q[k], done_cyc_q[k] + 1);
        end
    endtask

    task automatic check_final(input string tag, input logic [31:0] n);
        bit legal;
        bit err;
        legal = (n >= 1) && (n <= DEPTH);
        err   = (n > DEPTH);
        chk({tag, "_done"}, done, !err);
        chk({tag, "_error"}, error, err);
        chk({tag, "_hold"}, hold_cpu, err);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_words"}, words_loaded, legal ? n : 0);
        if (legal) begin
            chk({tag, "_addr_hold"}, mem_addr, n - 1);
            chk({tag, "_data_hold"}, mem_wdata, gen_words[n-1]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_words"}, words_loaded, 0);
        chk({tag, "_hold"}, hold_cpu, 1);
    endtask

    task automatic run_load(input string tag, input logic [31:0] n, input bit throttle);
        int nw;
        nw = (n >= 1 && n <= DEPTH) ? int'(n) : 0;
        build_bytes(n);
        model_load(n, nw);
        start_load();
        drive_bytes(4 + 4 * nw, -1, throttle);
        check_writes(tag);
        check_final(tag, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] n;
        int wl_before;

        // Reset for two cycles
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // Basic load at full rate
        gen_words.delete();
        gen_words.push_back(32'hDEADBEEF);
        gen_words.push_back(32'h12345678);
        run_load("basic", 32'd2, 1'b0);

        // Junk on the stream after DONE must be ignored
        wl_before = obs_q.size();
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("junk_no_write", obs_q.size(), wl_before);
        chk("junk_words", words_loaded, 2);
        chk("junk_done", done, 1);

        // Same stream, throttled
        run_load("throttle", 32'd2, 1'b1);

        // Random sizes and payloads, throttled
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, DEPTH - 1);
            rand_words(int'(n));
            run_load($sformatf("rand%0d", r), n, 1'b1);
        end

        // Full memory
        rand_words(DEPTH);
        run_load("full", DEPTH, 1'b0);
        chk("full_last_addr", obs_q.size() > 0 ? obs_q[obs_q.size()-1][35:32] : 4'hx, DEPTH - 1);

        // Over-size headers, including one whose low bits look legal
        gen_words.delete();
        run_load("over17", 32'd17, 1'b1);
        run_load("over_hi", 32'h0001_0001, 1'b0);

        // Empty load
        gen_words.delete();
        run_load("empty", 32'd0, 1'b0);

        // Reset after 6 of 12 data bytes
        rand_words(3);
        build_bytes(32'd3);
        model_load(32'd3, 1);
        start_load();
        drive_bytes(4 + 6, -1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_writes("midrst");

        // Restart with a new stream; a start pulse during DATA is ignored
        rand_words(3);
        build_bytes(32'd3);
        model_load(32'd3, 3);
        start_load();
        drive_bytes(16, 6, 1'b1);
        check_writes("restart");
        check_final("restart", 32'd3);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the fetch-stage instruction memory. The fetch stage reads one 32-bit word per clock at address PC; this block fills that memory.
- Receives a byte stream over a valid/ready handshake and assembles it big-endian into 32-bit words.
- Writes words to consecutive word addresses starting at 0, holding the CPU in stall until the load completes.
- Stream format: a 4-byte header giving the word count N, then N×4 data bytes.

Parameters:
- DEPTH, 16, number of 32-bit words in instruction memory (max legal N).
- ADDR_W, 4, memory word-address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
- in_valid  input  1  byte stream valid.
- in_data  input  8  byte stream data, MSB byte of each word first.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  word to write.
- busy  output  1  high in HDR or DATA.
- done  output  1  level; last load completed successfully.
- error  output  1  level; header count exceeded DEPTH.
- hold_cpu  output  1  stall request to the PC/fetch stage.
- words_loaded  output  ADDR_W+1  number of words written in the current load.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; byte counter=0; word index=0.
  - Outputs: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_loaded=0, hold_cpu=1.
  - rst mid-load discards any partial word. Memory contents already written are not touched. No write strobe is issued after reset.
- Byte accept occurs when in_valid & in_ready at posedge.
  - Bytes shift into the assembly register: asm <= {asm[23:0], in_data}.
  - A 2-bit byte counter wraps 3 -> 0; the 4th accept completes a word.
- States:
  - IDLE:
    - in_ready=0; hold_cpu=1.
    - start -> HDR; clears done, error, words_loaded, word index.
  - HDR:
    - in_ready=1; busy=1.
    - On the 4th accepted byte, evaluate N = the completed word.
    - N==0 -> DONE.
    - N>DEPTH -> ERROR (full 32-bit compare).
    - Otherwise latch N -> DATA.
  - DATA:
    - in_ready=1; busy=1.
    - On each completed word, the next cycle drives mem_we=1 for exactly one cycle, with mem_addr=word index and mem_wdata=assembled word. Write latency from the 4th byte accept is 1 clock.
    - word index and words_loaded increment with the strobe.
    - in_ready stays high during the strobe cycle, so full-rate back-to-back bytes are legal. No bytes are dropped or stalled.
    - On the completed word that is the Nth: in_ready drops the following cycle, no further bytes are accepted, and the state moves to DONE when the strobe issues.
  - DONE:
    - done=1; hold_cpu=0; in_ready=0; busy=0.
    - Remains in DONE until start or rst.
  - ERROR:
    - error=1; hold_cpu=1; in_ready=0; busy=0.
    - Remains in ERROR until start or rst.
- start is ignored in HDR and DATA.
- start from DONE or ERROR restarts at HDR: done/error clear and hold_cpu=1 from the next cycle.
- in_data is ignored whenever in_ready=0.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- N==DEPTH is legal. The last address is DEPTH-1; the word index never wraps.

Test Plan:
- Reset: apply rst for 2 cycles, then release -> all outputs at reset values; hold_cpu=1; in_ready=0.
- Basic load: start; stream 00 00 00 02, DE AD BE EF, 12 34 56 78 at full rate.
  - -> mem_we pulses twice: (addr 0, DEADBEEF), then (addr 1, 12345678), each 1 cycle after the word's 4th byte.
  - -> done=1, hold_cpu=0, words_loaded=2.
- Throttled input: same stream as the basic load, with in_valid toggled randomly -> identical writes and data; no byte is lost or duplicated.
- Full and over-size headers:
  - N=16 with 64 data bytes -> last write at addr 15; done=1.
  - N=17 -> error=1; no mem_we; hold_cpu=1; in_ready=0.
- Empty load: N=0 -> DONE with no mem_we; words_loaded=0.
- Reset and restart:
  - rst after 6 of 12 data bytes -> reset values next cycle; no further mem_we.
  - Then start plus a new stream -> load completes normally.
  - start pulsed during DATA is ignored.
